// File: rtl/port_arbiter.sv
// Round-robin output-port arbiter: one-hot registered grant, hold-while-requesting,
// one-cycle gap after release. ARB_HOLD_TIMEOUT_EN adds a MAX_HOLD forced release.
module port_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 16,
  parameter int IDW      = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id,
  output logic           busy,
  output logic           preempt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  logic [1:0]     state;
  logic [IDW-1:0] ptr;
  logic           found;
  logic [IDW-1:0] pick;
  logic [IDW-1:0] ptr_next;
  logic           held;
  logic           timeout;

  // First requester at or after ptr, wrapping modulo N.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = IDW'(idx);
      end
    end
  end

  assign ptr_next = (int'(pick) == N - 1) ? '0 : IDW'(int'(pick) + 1);
  assign held     = req[grant_id];

`ifdef ARB_HOLD_TIMEOUT_EN
  logic [7:0] hold_cnt;

  assign timeout = (hold_cnt == 8'(MAX_HOLD));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= 8'd0;
      preempt  <= 1'b0;
    end else begin
      // A drop on the terminal count is a normal release, so held gates the pulse.
      preempt <= (state == GRANT) && held && timeout;
      if (state == IDLE && found) begin
        hold_cnt <= 8'd1;
      end else if (state == GRANT && held && !timeout) begin
        hold_cnt <= hold_cnt + 8'd1;
      end
    end
  end
`else
  assign timeout = 1'b0;
  assign preempt = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      grant    <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant       <= '0;
            grant[pick] <= 1'b1;
            grant_id    <= pick;
            busy        <= 1'b1;
            ptr         <= ptr_next;
            state       <= GRANT;
          end
        end
        GRANT: begin
          if (!held || timeout) begin
            grant <= '0;
            busy  <= 1'b0;
            state <= GAP;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          grant <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_port_arbiter.sv
// Self-checking bench for port_arbiter: directed scenarios plus random traffic against
// a behavioural model of holder / turnaround / round-robin order.
module tb_port_arbiter;

  localparam int NR   = 4;
  localparam int MAXH = 16;
`ifdef ARB_HOLD_TIMEOUT_EN
  localparam bit TIMEOUT = 1'b1;
`else
  localparam bit TIMEOUT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NR-1:0] req = '0;
  logic [NR-1:0] grant;
  logic [1:0]    grant_id;
  logic          busy;
  logic          preempt;

  int checks   = 0;
  int failures = 0;

  // Model: current holder (-1 none), idle cycles still owed, next rr start, grant age.
  int m_holder, m_cool, m_rr, m_hold;
  bit m_pre;

  int winners[$];
  int gaps[$];
  int zrun;
  logic [NR-1:0] prev_grant;

  port_arbiter #(.N(NR), .MAX_HOLD(MAXH)) dut (
    .clk(clk), .rst(rst), .req(req), .grant(grant),
    .grant_id(grant_id), .busy(busy), .preempt(preempt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_holder = -1; m_cool = 0; m_rr = 0; m_hold = 0; m_pre = 1'b0;
    winners.delete(); gaps.delete(); zrun = 0; prev_grant = '0;
  endtask

  task automatic model_step(input logic [NR-1:0] r);
    if (m_holder >= 0) begin
      m_pre = 1'b0;
      if (!r[m_holder]) begin
        m_holder = -1; m_cool = 1;
      end else if (TIMEOUT && m_hold == MAXH) begin
        m_holder = -1; m_cool = 1; m_pre = 1'b1;
      end else begin
        m_hold++;
      end
    end else if (m_cool > 0) begin
      m_cool = 0; m_pre = 1'b0;
    end else begin
      m_pre = 1'b0;
      for (int k = 0; k < NR; k++) begin
        int i;
        i = (m_rr + k) % NR;
        if (r[i]) begin
          m_holder = i; m_rr = (i + 1) % NR; m_hold = 1;
          break;
        end
      end
    end
  endtask

  task automatic check_model();
    logic [NR-1:0] eg;
    eg = '0;
    if (m_holder >= 0) eg[m_holder] = 1'b1;
    check("grant", 32'(grant), 32'(eg));
    check("busy", 32'(busy), 32'(m_holder >= 0));
    check("preempt", 32'(preempt), 32'(m_pre));
    if (m_holder >= 0) check("grant_id", 32'(grant_id), 32'(m_holder));
  endtask

  task automatic monitor();
    if (grant != '0) begin
      if (prev_grant == '0) begin
        for (int i = 0; i < NR; i++) if (grant[i]) winners.push_back(i);
        gaps.push_back(zrun);
      end
      zrun = 0;
    end else begin
      zrun++;
    end
    prev_grant = grant;
  endtask

  task automatic tick(input logic [NR-1:0] r);
    req = r;
    @(posedge clk);
    model_step(r);
    @(negedge clk);
    check_model();
    monitor();
  endtask

  // Drive base, but drop the holder's line for one cycle once it has held len cycles.
  task automatic run_drop(input logic [NR-1:0] base, input int len, input int cycles);
    logic [NR-1:0] r;
    for (int c = 0; c < cycles; c++) begin
      r = base;
      if (m_holder >= 0 && m_hold == len) r[m_holder] = 1'b0;
      tick(r);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int cnt0, pcount;
    logic [NR-1:0] r;

    // Reset with all requests high.
    req = 4'b1111;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_preempt", 32'(preempt), 32'h0);
    rst = 1'b0;
    model_reset();
    tick(4'b1111);
    check("first_grant", 32'(grant), 32'h1);

    // Rotation: every winner releases after 3 grant cycles.
    do_reset();
    run_drop(4'b1111, 3, 30);
    check("rot_count", 32'(winners.size() >= 5), 32'h1);
    for (int k = 0; k < 5; k++) check("rot_order", 32'(winners[k]), 32'(k % 4));
    for (int k = 1; k < 5; k++) check("rot_gap", 32'(gaps[k]), 32'h2);

    // Wrap and skip: win with 2 so ptr=3, then 4'b0101 alternates 0,2,0.
    do_reset();
    run_drop(4'b0100, 2, 3);
    run_drop(4'b0101, 2, 20);
    check("wrap_count", 32'(winners.size() >= 4), 32'h1);
    check("wrap_w0", 32'(winners[1]), 32'h0);
    check("wrap_w1", 32'(winners[2]), 32'h2);
    check("wrap_w2", 32'(winners[3]), 32'h0);

    // Async reset between edges while requester 2 holds.
    do_reset();
    tick(4'b0100);
    tick(4'b0100);
    check("pre_async_grant", 32'(grant), 32'h4);
    #2 rst = 1'b1;
    #1;
    check("async_grant", 32'(grant), 32'h0);
    check("async_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    tick(4'b1111);
    check("post_async_grant", 32'(grant), 32'h1);

`ifdef ARB_HOLD_TIMEOUT_EN
    // Requester 0 never drops: forced release after MAX_HOLD, then requester 1.
    do_reset();
    cnt0 = 0; pcount = 0;
    for (int c = 0; c < 30; c++) begin
      tick(4'b0011);
      if (grant == 4'b0001) cnt0++;
      if (preempt) pcount++;
    end
    check("to_hold", 32'(cnt0), 32'(MAXH));
    check("to_pulse", 32'(pcount), 32'h1);
    check("to_next", 32'(winners[1]), 32'h1);

    // Drop coincident with terminal count is a normal release.
    do_reset();
    pcount = 0;
    for (int c = 0; c < 20; c++) begin
      r = 4'b0001;
      if (m_holder >= 0 && m_hold == MAXH) r = 4'b0000;
      tick(r);
      if (preempt) pcount++;
    end
    check("coinc_preempt", 32'(pcount), 32'h0);
    check("coinc_regrant", 32'(winners.size()), 32'h2);
`endif

    // Random traffic; holders mostly keep requesting so long holds occur.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      r = NR'($urandom);
      if (m_holder >= 0 && $urandom_range(0, 7) != 0) r[m_holder] = 1'b1;
      tick(r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
